// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder_pkg : shared types and address decode helper          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] index;
    } addr_chk_t;

    // Address is zero-extended to 64 bits so one helper serves any ADDR_W <= 64.
    function automatic addr_chk_t checkAddr(input logic [63:0] addr, input int unsigned depthWords);
        addr_chk_t res;
        res.index = addr[33:2];
        res.err   = (addr[1:0] != 2'b00) ||
                    (addr >= (64'(depthWords) * 64'(WORD_BYTES)));
        return res;
    endfunction

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_word_array : DEPTH_WORDS x 32 storage, synchronous write,       |
// |                  combinational read, no reset                       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_word_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_wrEn,
    input  logic [IDX_W-1:0] i_index,
    input  logic [31:0]      i_wrData,
    output logic [31:0]      o_rdData
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_index] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_index];

endmodule : mem_word_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder : single-outstanding word memory responder with       |
// |                 configurable wait states                            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              Ready,
    output logic              Err,
    output logic              Busy
);

    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

    state_t              r_state;
    state_t              w_stateNext;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cntNext;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic [31:0]         r_dataOut;
    logic                r_err;

    logic                w_accept;
    logic                w_enterResp;
    logic                w_accWr;
    logic [ADDR_W-1:0]   w_accAddr;
    logic [31:0]         w_accData;
    addr_chk_t           w_chk;
    logic [c_IDX_W-1:0]  w_idx;
    logic [31:0]         w_rdData;
    logic                w_memWe;

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_accept    = 1'b0;
        w_enterResp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    w_accept  = 1'b1;
                    w_cntNext = c_WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        w_stateNext = ST_RESP;
                        w_enterResp = 1'b1;
                    end else begin
                        w_stateNext = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_stateNext = ST_RESP;
                    w_enterResp = 1'b1;
                    w_cntNext   = 4'd0;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the access happens on the accepting edge,
    // before the request registers hold it, so take the live inputs then.
    assign w_accWr   = (r_state == ST_IDLE) ? Wr      : r_wr;
    assign w_accAddr = (r_state == ST_IDLE) ? Address : r_addr;
    assign w_accData = (r_state == ST_IDLE) ? DataIn  : r_data;

    assign w_chk   = checkAddr(64'(w_accAddr), DEPTH_WORDS);
    assign w_idx   = c_IDX_W'(w_chk.index);
    assign w_memWe = Reset && w_enterResp && w_accWr && !w_chk.err;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk      (Clk),
        .i_wrEn   (w_memWe),
        .i_index  (w_idx),
        .i_wrData (w_accData),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_data    <= 32'd0;
            r_dataOut <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_accept) begin
                r_wr   <= Wr;
                r_addr <= Address;
                r_data <= DataIn;
            end
            if (w_enterResp) begin
                r_err <= w_chk.err;
                if (!w_accWr && !w_chk.err) begin
                    r_dataOut <= w_rdData;
                end
            end
        end
    end

    assign Ready   = (r_state == ST_RESP);
    assign Busy    = (r_state != ST_IDLE);
    assign Err     = Ready && r_err;
    assign DataOut = r_dataOut;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_responder : three responders (1, 0, 15 wait states) against  |
// |                    an address-keyed reference memory                |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mem_responder;

    logic        clk;
    logic        rstN;
    logic        req   [3];
    logic        tbWr  [3];
    logic [31:0] addr  [3];
    logic [31:0] din   [3];
    logic [31:0] dout  [3];
    logic        ready [3];
    logic        err   [3];
    logic        busy  [3];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [int];
    logic [31:0] rdv [3];
    logic [31:0] pool [8];

    function automatic int wsOf(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
        mem_responder #(
            .DEPTH_WORDS (256),
            .WAIT_STATES (WS),
            .ADDR_W      (32)
        ) u_dut (
            .Clk     (clk),
            .Reset   (rstN),
            .Req     (req[g]),
            .Wr      (tbWr[g]),
            .Address (addr[g]),
            .DataIn  (din[g]),
            .DataOut (dout[g]),
            .Ready   (ready[g]),
            .Err     (err[g]),
            .Busy    (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int keyOf(input int d, input logic [31:0] a);
        return d * 4096 + int'(a[11:2]);
    endfunction

    // One complete transaction: latency, Err, DataOut and idle return are all checked.
    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] data);
        int lat;
        bit e;
        e = (a[1:0] != 2'b00) || (a >= 32'h400);
        @(negedge clk);
        req[d] = 1'b1; tbWr[d] = w; addr[d] = a; din[d] = data;
        @(posedge clk); #1;
        req[d] = 1'b0; tbWr[d] = 1'($urandom); addr[d] = $urandom; din[d] = $urandom;
        chk("busy_after_accept", 32'(busy[d]), 32'd1);
        lat = 1;
        while (!ready[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, wsOf(d) + 1);
        if (!e) begin
            if (w) mdl[keyOf(d, a)] = data;
            else if (mdl.exists(keyOf(d, a))) rdv[d] = mdl[keyOf(d, a)];
        end
        chk("err", 32'(err[d]), 32'(e));
        chk("dataout", dout[d], rdv[d]);
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(ready[d]), 32'd0);
        chk("busy_released", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] lastA;
        int          ws;
        int          p;
        int          pulses;
        int          r;

        pool[0] = 32'h000; pool[1] = 32'h010; pool[2] = 32'h014; pool[3] = 32'h020;
        pool[4] = 32'h3FC; pool[5] = 32'h100; pool[6] = 32'h200; pool[7] = 32'h040;
        rstN = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; tbWr[d] = 1'b0; addr[d] = 32'd0; din[d] = 32'd0; rdv[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", 32'(ready[d]), 32'd0);
            chk("reset_busy", 32'(busy[d]), 32'd0);
            chk("reset_err", 32'(err[d]), 32'd0);
            chk("reset_dataout", dout[d], 32'd0);
        end
        @(negedge clk);
        rstN = 1'b1;

        // Basic write then read back.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 32'h0);

        // Preload every pool word so later reads have known contents.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                access(d, 1'b1, pool[i], (pool[i] == 32'h20) ? 32'h0 : $urandom);
            end
        end

        // Misaligned read/write, out-of-range write aliasing word 0, top word.
        access(0, 1'b0, 32'h10, 32'h0);
        access(0, 1'b0, 32'h12, 32'h0);
        access(0, 1'b1, 32'h12, 32'hA5A5A5A5);
        access(0, 1'b0, 32'h10, 32'h0);
        access(0, 1'b1, 32'h400, 32'hCAFEF00D);
        access(0, 1'b0, 32'h000, 32'h0);
        access(0, 1'b0, 32'h3FC, 32'h0);

        // Req held high: one acceptance per WAIT_STATES+2 cycles.
        ws = wsOf(0);
        @(negedge clk);
        req[0] = 1'b1; tbWr[0] = 1'b0; addr[0] = 32'h10;
        lastA = 32'h10;
        for (int k = 0; k < 4 * (ws + 2); k++) begin
            @(posedge clk); #1;
            p = k % (ws + 2);
            if (p == 0) lastA = addr[0];
            chk("hold_ready", 32'(ready[0]), 32'(p == ws));
            chk("hold_busy", 32'(busy[0]), 32'(p != ws + 1));
            if (p == ws) begin
                rdv[0] = mdl[keyOf(0, lastA)];
                chk("hold_dataout", dout[0], rdv[0]);
            end
            @(negedge clk);
            addr[0] = (addr[0] == 32'h10) ? 32'h14 : 32'h10;
            if (k == 4 * (ws + 2) - 1) req[0] = 1'b0;
        end

        // Reset in the middle of a long WAIT drops the write.
        @(negedge clk);
        req[2] = 1'b1; tbWr[2] = 1'b1; addr[2] = 32'h20; din[2] = 32'h12345678;
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            rdv[d] = 32'd0;
            chk("midreset_busy", 32'(busy[d]), 32'd0);
            chk("midreset_ready", 32'(ready[d]), 32'd0);
            chk("midreset_dataout", dout[d], 32'd0);
        end
        @(negedge clk);
        rstN = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ready[2]) pulses++;
        end
        chk("no_ready_after_reset", pulses, 0);
        access(2, 1'b0, 32'h20, 32'h0);

        // Randomized traffic across all three latency builds.
        for (int n = 0; n < 30; n++) begin
            int d;
            d = int'($urandom_range(0, 2));
            a = pool[$urandom_range(0, 7)];
            r = int'($urandom_range(0, 7));
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
            if (r == 2) a = a | 32'h8000_0000;
            access(d, 1'($urandom), a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
